lif_neuron: RTL and testbench
=============================

// Module: lif_neuron
// PURPOSE
//  Leaky integrate-and-fire neuron between the synapse input and the STDP learning block.
//  Integrates the current synaptic weight on each pre-synaptic spike and applies a shift-based leak.
//  Emits a one-cycle post_spike that drives the STDP block's post_spike input, then enforces a refractory period.
// PARAMETERS
//  W_WIDTH        16   width of incoming synaptic weight (matches STDP weight output)
//  V_WIDTH        16   membrane potential width, unsigned, must be >= W_WIDTH
//  THRESHOLD      100  fire when next potential >= THRESHOLD; legal range 1..2^V_WIDTH-1
//  LEAK_SHIFT     3    leak per cycle = v >> LEAK_SHIFT; legal range 1..V_WIDTH-1
//  REFRACT_CYCLES 4    cycles spent in REFRAC after a fire; 0 = no refractory period
// PORTS
//  clk          in   1        clock
//  rst_n        in   1        reset, synchronous, active-low
//  en           in   1        neuron update enable; low = freeze all state
//  pre_spike    in   1        pre-synaptic spike, one sample per clk
//  weight       in   W_WIDTH  synaptic weight, unsigned, sampled with pre_spike
//  post_spike   out  1        registered fire pulse, exactly one cycle wide
//  membrane     out  V_WIDTH  current membrane potential (register value)
//  refractory   out  1        high while FSM is in REFRAC
//  spike_count  out  16       fires since reset (present only with LIF_SPIKE_CNT_EN)
// BEHAVIOUR
//  Reset: membrane=0, post_spike=0, refractory=0, FSM=INTEG, refractory counter=0, spike_count=0.
//  Reset takes priority over en and over every state, including mid-REFRAC.
//  en=0: membrane, FSM and counter hold; post_spike=0; pre_spike ignored.
//  FSM has two states, INTEG and REFRAC. All rules below apply only when en=1.
//  INTEG:
//   - leaked   = v - (v >> LEAK_SHIFT), computed in V_WIDTH bits; no underflow is possible.
//   - sum      = leaked + (pre_spike ? zero-extended weight : 0), computed in V_WIDTH+1 bits.
//   - v_next   = saturate(sum) to 2^V_WIDTH-1; the potential never wraps.
//   - If v_next >= THRESHOLD: post_spike<=1, membrane<=0, counter<=REFRACT_CYCLES.
//     The FSM moves to REFRAC, or stays in INTEG if REFRACT_CYCLES==0.
//   - Otherwise: membrane<=v_next, post_spike<=0.
//  Latency: pre_spike sampled on edge N produces post_spike high during cycle N+1.
//  REFRAC:
//   - membrane held at 0; pre_spike and weight ignored; post_spike=0.
//   - Counter decrements each cycle; when counter==1 the FSM returns to INTEG on the next edge.
//   - Result: exactly REFRACT_CYCLES cycles with refractory=1.
//  Small potentials where (v >> LEAK_SHIFT)==0 do not decay further. This is intended and deterministic.
//  Weight 0 with pre_spike=1 is equivalent to no spike.
// CONFIGURATION
//  LIF_SPIKE_CNT_EN defined:
//   - spike_count port exists.
//   - Increments by 1 on every cycle where post_spike is registered high.
//   - Saturates at 16'hFFFF. Cleared only by reset. Holds while en=0.
//  LIF_SPIKE_CNT_EN undefined: port and counter are absent; all other behaviour is identical.
// STRUCTURE
//  Shared package lif_pkg:
//   - state enum {ST_INTEG, ST_REFRAC}
//   - default width constants and default THRESHOLD, LEAK_SHIFT, REFRACT_CYCLES values
//  Sub-module lif_refrac_ctr:
//   - loadable down-counter with load/enable inputs and a done flag
//   - instantiated once for the refractory timer
//  Leak, accumulate and saturate datapath plus the FSM stay in lif_neuron.
// TESTING (THRESHOLD=100, LEAK_SHIFT=3, REFRACT_CYCLES=4 unless stated)
//  1. Hold rst_n=0 two cycles -> membrane=0, post_spike=0, refractory=0; release; no input -> all stay 0.
//  2. pre_spike=1, weight=50 for one cycle -> membrane 50, then 44, then 39 on the next edges; post_spike stays 0.
//  3. pre_spike=1, weight=100 from v=0 -> post_spike=1 for exactly one cycle, membrane=0, refractory=1 for 4 cycles.
//     pre_spike with weight=200 during REFRAC -> no effect.
//  4. THRESHOLD=16'hFFFF, drive v to 0x9000, then pre_spike with weight=0xF000 -> sum saturates to 0xFFFF and fires; no wrap to a low value.
//  5. rst_n=0 for one cycle at the 2nd REFRAC cycle -> next cycle FSM=INTEG, refractory=0, membrane=0; spike_count=0 if enabled.
//  6. en=0 for 5 cycles with membrane=60 and pre_spike pulses -> membrane stays 60, no fire.
//     With LIF_SPIKE_CNT_EN: 3 fires -> spike_count=3.

Source files
------------

// File: rtl/lif_pkg.sv
// -----------------------------------------------------------------------------
// lif_pkg
// Shared definitions for the leaky integrate-and-fire neuron:
//   - lif_state_t : neuron FSM state encoding (integrate / refractory)
//   - default widths and default neuron tuning constants
// No ports (package).
// -----------------------------------------------------------------------------
package lif_pkg;

    typedef enum logic [0:0] {
        ST_INTEG  = 1'b0,
        ST_REFRAC = 1'b1
    } lif_state_t;

    localparam int unsigned LIF_W_WIDTH        = 16;
    localparam int unsigned LIF_V_WIDTH        = 16;
    localparam int unsigned LIF_CNT_WIDTH      = 16;
    localparam int unsigned LIF_THRESHOLD      = 100;
    localparam int unsigned LIF_LEAK_SHIFT     = 3;
    localparam int unsigned LIF_REFRACT_CYCLES = 4;

endpackage

// File: rtl/lif_refrac_ctr.sv
// -----------------------------------------------------------------------------
// lif_refrac_ctr
// Loadable down-counter used as the refractory timer.
// Ports:
//   clk      in  1   clock
//   rst_n    in  1   synchronous active-low reset (count -> 0)
//   load     in  1   load load_val (has priority over dec_en)
//   dec_en   in  1   decrement by one; stops at zero
//   load_val in  CW  value to load
//   done     out 1   high while the count is 1, i.e. the last timed cycle
// -----------------------------------------------------------------------------
module lif_refrac_ctr
    import lif_pkg::*;
#(
    parameter int unsigned CW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          dec_en,
    input  logic [CW-1:0] load_val,
    output logic          done
);

    logic [CW-1:0] count_r;

    // Count register: reset, load, or saturating decrement toward zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= {CW{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (dec_en && (count_r != {CW{1'b0}})) begin
            count_r <= count_r - CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign done = (count_r == CW'(1));

endmodule

// File: rtl/lif_neuron.sv
// -----------------------------------------------------------------------------
// lif_neuron
// Leaky integrate-and-fire neuron. On each enabled cycle in INTEG the membrane
// potential leaks by v >> LEAK_SHIFT, adds the synaptic weight when pre_spike
// is high, and saturates at all-ones. Reaching THRESHOLD emits a one-cycle
// post_spike, clears the membrane and (if REFRACT_CYCLES > 0) enters REFRAC
// for exactly REFRACT_CYCLES cycles, during which input is ignored.
// Optional feature macro: LIF_SPIKE_CNT_EN adds the saturating spike_count.
// Ports:
//   clk         in  1        clock
//   rst_n       in  1        synchronous active-low reset, overrides everything
//   en          in  1        update enable; low freezes all state
//   pre_spike   in  1        pre-synaptic spike
//   weight      in  W_WIDTH  unsigned synaptic weight, sampled with pre_spike
//   post_spike  out 1        registered one-cycle fire pulse
//   membrane    out V_WIDTH  membrane potential register
//   refractory  out 1        high while in REFRAC
//   spike_count out 16       fires since reset (LIF_SPIKE_CNT_EN only)
// -----------------------------------------------------------------------------
module lif_neuron
    import lif_pkg::*;
#(
    parameter int unsigned W_WIDTH        = LIF_W_WIDTH,
    parameter int unsigned V_WIDTH        = LIF_V_WIDTH,
    parameter int unsigned THRESHOLD      = LIF_THRESHOLD,
    parameter int unsigned LEAK_SHIFT     = LIF_LEAK_SHIFT,
    parameter int unsigned REFRACT_CYCLES = LIF_REFRACT_CYCLES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               pre_spike,
    input  logic [W_WIDTH-1:0] weight,
    output logic               post_spike,
    output logic [V_WIDTH-1:0] membrane,
    output logic               refractory
`ifdef LIF_SPIKE_CNT_EN
    ,
    output logic [LIF_CNT_WIDTH-1:0] spike_count
`endif
);

    // Counter just wide enough to hold REFRACT_CYCLES (at least one bit).
    localparam int unsigned CW = (REFRACT_CYCLES < 2) ? 1 : $clog2(REFRACT_CYCLES + 1);
    localparam logic [V_WIDTH-1:0] THRESH_V   = V_WIDTH'(THRESHOLD);
    localparam logic               HAS_REFRAC = (REFRACT_CYCLES != 0);

    lif_state_t         state_r;
    lif_state_t         state_next_s;
    logic [V_WIDTH-1:0] membrane_r;
    logic [V_WIDTH-1:0] membrane_next_s;
    logic               post_spike_r;
    logic               post_next_s;
    logic               refractory_r;
    logic [V_WIDTH-1:0] leaked_s;
    logic [V_WIDTH:0]   weight_ext_s;
    logic [V_WIDTH:0]   sum_s;
    logic [V_WIDTH-1:0] v_next_s;
    logic               fire_s;
    logic               ctr_load_s;
    logic               ctr_dec_s;
    logic               ctr_done_s;

    // Leak, accumulate and saturate datapath for the integrate state.
    always_comb begin
        leaked_s = membrane_r - (membrane_r >> LEAK_SHIFT);
        if (pre_spike) begin
            weight_ext_s = {{(V_WIDTH + 1 - W_WIDTH){1'b0}}, weight};
        end else begin
            weight_ext_s = {(V_WIDTH + 1){1'b0}};
        end
        sum_s = {1'b0, leaked_s} + weight_ext_s;
        // Carry out of V_WIDTH bits means overflow: clamp instead of wrapping.
        if (sum_s[V_WIDTH]) begin
            v_next_s = {V_WIDTH{1'b1}};
        end else begin
            v_next_s = sum_s[V_WIDTH-1:0];
        end
        fire_s = (v_next_s >= THRESH_V);
    end

    // FSM next-state, next membrane value and refractory timer control.
    always_comb begin
        state_next_s    = state_r;
        membrane_next_s = membrane_r;
        post_next_s     = 1'b0;
        ctr_load_s      = 1'b0;
        ctr_dec_s       = 1'b0;
        if (en) begin
            case (state_r)
                ST_INTEG: begin
                    if (fire_s) begin
                        post_next_s     = 1'b1;
                        membrane_next_s = {V_WIDTH{1'b0}};
                        ctr_load_s      = 1'b1;
                        if (HAS_REFRAC) begin
                            state_next_s = ST_REFRAC;
                        end else begin
                            state_next_s = ST_INTEG;
                        end
                    end else begin
                        membrane_next_s = v_next_s;
                    end
                end
                ST_REFRAC: begin
                    membrane_next_s = {V_WIDTH{1'b0}};
                    ctr_dec_s       = 1'b1;
                    if (ctr_done_s) begin
                        state_next_s = ST_INTEG;
                    end else begin
                        state_next_s = ST_REFRAC;
                    end
                end
                default: begin
                    state_next_s    = ST_INTEG;
                    membrane_next_s = {V_WIDTH{1'b0}};
                end
            endcase
        end else begin
            state_next_s    = state_r;
            membrane_next_s = membrane_r;
        end
    end

    // State and output registers; refractory is registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_INTEG;
            membrane_r   <= {V_WIDTH{1'b0}};
            post_spike_r <= 1'b0;
            refractory_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            membrane_r   <= membrane_next_s;
            post_spike_r <= post_next_s;
            refractory_r <= (state_next_s == ST_REFRAC);
        end
    end

    lif_refrac_ctr #(
        .CW (CW)
    ) u_refrac_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ctr_load_s),
        .dec_en   (ctr_dec_s),
        .load_val (CW'(REFRACT_CYCLES)),
        .done     (ctr_done_s)
    );

    assign post_spike = post_spike_r;
    assign membrane   = membrane_r;
    assign refractory = refractory_r;

`ifdef LIF_SPIKE_CNT_EN
    logic [LIF_CNT_WIDTH-1:0] spike_cnt_r;

    // Saturating fire counter, stepped on the same edge that registers post_spike.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            spike_cnt_r <= {LIF_CNT_WIDTH{1'b0}};
        end else if (post_next_s && (spike_cnt_r != {LIF_CNT_WIDTH{1'b1}})) begin
            spike_cnt_r <= spike_cnt_r + LIF_CNT_WIDTH'(1);
        end else begin
            spike_cnt_r <= spike_cnt_r;
        end
    end

    assign spike_count = spike_cnt_r;
`endif

endmodule

// File: tb/tb_lif_neuron.sv
// -----------------------------------------------------------------------------
// tb_lif_neuron
// Directed, table-driven bench for lif_neuron. dut1 uses the default tuning
// (THRESHOLD=100, LEAK_SHIFT=3, REFRACT_CYCLES=4); dut2 uses THRESHOLD=16'hFFFF
// for the saturation case. Inputs change 1 ns after the rising edge and
// outputs are checked there, well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_lif_neuron;

    logic        clk = 1'b0;
    logic        rst_n1, en1, pre1;
    logic [15:0] w1;
    logic        post1, ref1;
    logic [15:0] mem1;
    logic        rst_n2, en2, pre2;
    logic [15:0] w2;
    logic        post2, ref2;
    logic [15:0] mem2;
`ifdef LIF_SPIKE_CNT_EN
    logic [15:0] cnt1;
    logic [15:0] cnt2;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        rst_n;
        logic        en;
        logic        pre;
        logic [15:0] w;
        logic        exp_post;
        logic [15:0] exp_mem;
        logic        exp_ref;
    } vec_t;

    vec_t vq[$];

    always #5 clk = ~clk;

    lif_neuron dut1 (
        .clk        (clk),
        .rst_n      (rst_n1),
        .en         (en1),
        .pre_spike  (pre1),
        .weight     (w1),
        .post_spike (post1),
        .membrane   (mem1),
        .refractory (ref1)
`ifdef LIF_SPIKE_CNT_EN
        ,
        .spike_count(cnt1)
`endif
    );

    lif_neuron #(
        .THRESHOLD (16'hFFFF)
    ) dut2 (
        .clk        (clk),
        .rst_n      (rst_n2),
        .en         (en2),
        .pre_spike  (pre2),
        .weight     (w2),
        .post_spike (post2),
        .membrane   (mem2),
        .refractory (ref2)
`ifdef LIF_SPIKE_CNT_EN
        ,
        .spike_count(cnt2)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic e, input logic p, input logic [15:0] w,
                       input logic po, input logic [15:0] m, input logic rf);
        vec_t v;
        v.rst_n = r; v.en = e; v.pre = p; v.w = w;
        v.exp_post = po; v.exp_mem = m; v.exp_ref = rf;
        vq.push_back(v);
    endtask

    task automatic drive1(input logic r, input logic e, input logic p, input logic [15:0] w);
        rst_n1 = r; en1 = e; pre1 = p; w1 = w;
    endtask

    initial begin
        rst_n1 = 1'b0; en1 = 1'b1; pre1 = 1'b0; w1 = 16'd0;
        rst_n2 = 1'b0; en2 = 1'b1; pre2 = 1'b0; w2 = 16'd0;

        //    rst  en   pre  weight     post mem      ref
        add(1'b0, 1'b1, 1'b0, 16'd0,   1'b0, 16'd0,  1'b0); // reset cycle 1
        add(1'b0, 1'b1, 1'b0, 16'd0,   1'b0, 16'd0,  1'b0); // reset cycle 2
        add(1'b1, 1'b1, 1'b0, 16'd0,   1'b0, 16'd0,  1'b0); // idle
        add(1'b1, 1'b1, 1'b0, 16'd0,   1'b0, 16'd0,  1'b0); // idle
        add(1'b1, 1'b1, 1'b1, 16'd50,  1'b0, 16'd50, 1'b0); // integrate 50
        add(1'b1, 1'b1, 1'b0, 16'd0,   1'b0, 16'd44, 1'b0); // leak 50-6
        add(1'b1, 1'b1, 1'b0, 16'd0,   1'b0, 16'd39, 1'b0); // leak 44-5
        add(1'b0, 1'b1, 1'b0, 16'd0,   1'b0, 16'd0,  1'b0); // reset
        add(1'b1, 1'b1, 1'b1, 16'd100, 1'b1, 16'd0,  1'b1); // fire at threshold
        add(1'b1, 1'b1, 1'b1, 16'd200, 1'b0, 16'd0,  1'b1); // refrac, input ignored
        add(1'b1, 1'b1, 1'b1, 16'd200, 1'b0, 16'd0,  1'b1);
        add(1'b1, 1'b1, 1'b1, 16'd200, 1'b0, 16'd0,  1'b1); // 4th refrac cycle
        add(1'b1, 1'b1, 1'b1, 16'd200, 1'b0, 16'd0,  1'b0); // back to INTEG, still ignored
        add(1'b1, 1'b1, 1'b0, 16'd0,   1'b0, 16'd0,  1'b0);
        add(1'b1, 1'b1, 1'b1, 16'd60,  1'b0, 16'd60, 1'b0); // membrane 60
        add(1'b1, 1'b0, 1'b1, 16'd200, 1'b0, 16'd60, 1'b0); // en=0 freeze x5
        add(1'b1, 1'b0, 1'b0, 16'd0,   1'b0, 16'd60, 1'b0);
        add(1'b1, 1'b0, 1'b1, 16'd200, 1'b0, 16'd60, 1'b0);
        add(1'b1, 1'b0, 1'b0, 16'd0,   1'b0, 16'd60, 1'b0);
        add(1'b1, 1'b0, 1'b1, 16'd200, 1'b0, 16'd60, 1'b0);
        add(1'b1, 1'b1, 1'b0, 16'd0,   1'b0, 16'd53, 1'b0); // resume: 60-7
        add(1'b1, 1'b1, 1'b1, 16'd0,   1'b0, 16'd47, 1'b0); // weight 0 = leak only
        add(1'b0, 1'b1, 1'b0, 16'd0,   1'b0, 16'd0,  1'b0); // reset
        add(1'b1, 1'b1, 1'b1, 16'd99,  1'b0, 16'd99, 1'b0); // one below threshold
        add(1'b1, 1'b1, 1'b1, 16'd0,   1'b0, 16'd87, 1'b0); // 99-12
        add(1'b0, 1'b1, 1'b0, 16'd0,   1'b0, 16'd0,  1'b0); // reset
        add(1'b1, 1'b1, 1'b1, 16'd7,   1'b0, 16'd7,  1'b0); // small potential
        add(1'b1, 1'b1, 1'b0, 16'd0,   1'b0, 16'd7,  1'b0); // 7>>3==0, no decay
        add(1'b1, 1'b1, 1'b1, 16'd93,  1'b1, 16'd0,  1'b1); // 7+93 = 100 fires

        for (int i = 0; i < vq.size(); i++) begin
            drive1(vq[i].rst_n, vq[i].en, vq[i].pre, vq[i].w);
            tick();
            chk($sformatf("vec%0d.post", i), {31'd0, post1}, {31'd0, vq[i].exp_post});
            chk($sformatf("vec%0d.mem", i),  {16'd0, mem1},  {16'd0, vq[i].exp_mem});
            chk($sformatf("vec%0d.ref", i),  {31'd0, ref1},  {31'd0, vq[i].exp_ref});
        end

        // en=0 freezes the refractory timer: 3 held + 3 counted cycles stay in REFRAC.
        for (int i = 0; i < 3; i++) begin
            drive1(1'b1, 1'b0, 1'b1, 16'd200);
            tick();
            chk("frz_ref_hold", {31'd0, ref1}, 32'd1);
            chk("frz_post", {31'd0, post1}, 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            drive1(1'b1, 1'b1, 1'b0, 16'd0);
            tick();
            chk("frz_ref_run", {31'd0, ref1}, 32'd1);
        end
        tick();
        chk("frz_ref_exit", {31'd0, ref1}, 32'd0);

        // Reset in the 2nd refractory cycle returns straight to INTEG.
        drive1(1'b1, 1'b1, 1'b1, 16'd100);
        tick();
        chk("rr_fire", {31'd0, post1}, 32'd1);
        drive1(1'b1, 1'b1, 1'b0, 16'd0);
        tick();
        chk("rr_in_refrac", {31'd0, ref1}, 32'd1);
        drive1(1'b0, 1'b1, 1'b1, 16'd200);
        tick();
        chk("rr_ref", {31'd0, ref1}, 32'd0);
        chk("rr_mem", {16'd0, mem1}, 32'd0);
        chk("rr_post", {31'd0, post1}, 32'd0);
`ifdef LIF_SPIKE_CNT_EN
        chk("rr_cnt", {16'd0, cnt1}, 32'd0);
`endif
        drive1(1'b1, 1'b1, 1'b1, 16'd100);
        tick();
        chk("rr_integ_fire", {31'd0, post1}, 32'd1);
        drive1(1'b1, 1'b1, 1'b0, 16'd0);
        tick();
        chk("rr_post_1cyc", {31'd0, post1}, 32'd0);

`ifdef LIF_SPIKE_CNT_EN
        // Three fires counted from reset; count holds while en=0.
        drive1(1'b0, 1'b1, 1'b0, 16'd0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive1(1'b1, 1'b1, 1'b1, 16'd150);
            tick();
            chk("cnt_fire", {31'd0, post1}, 32'd1);
            for (int j = 0; j < 4; j++) begin
                drive1(1'b1, 1'b1, 1'b0, 16'd0);
                tick();
            end
        end
        chk("cnt_three", {16'd0, cnt1}, 32'd3);
        for (int j = 0; j < 3; j++) begin
            drive1(1'b1, 1'b0, 1'b1, 16'd200);
            tick();
        end
        chk("cnt_hold_en0", {16'd0, cnt1}, 32'd3);
`endif

        // Saturation on dut2: 0x9000 leaks to 0x7E00, +0xF000 clamps to 0xFFFF.
        rst_n2 = 1'b0;
        tick();
        rst_n2 = 1'b1; pre2 = 1'b1; w2 = 16'h9000;
        tick();
        chk("sat_load", {16'd0, mem2}, 32'h9000);
        chk("sat_nofire", {31'd0, post2}, 32'd0);
        w2 = 16'hF000;
        tick();
        chk("sat_fire", {31'd0, post2}, 32'd1);
        chk("sat_mem", {16'd0, mem2}, 32'd0);
        chk("sat_ref", {31'd0, ref2}, 32'd1);
        pre2 = 1'b0; w2 = 16'd0;
        tick();
        chk("sat_post_end", {31'd0, post2}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
